// File: rtl/move_sequencer_if.sv
// Handshake bundle between game control and the move sequencer.
// master = game-control side issuing requests, slave = move_sequencer.
interface move_sequencer_if;
  logic [4:0] n_players;
  logic       start;
  logic [3:0] steps;
  logic       pass_turn;
  logic [3:0] p_da;
  logic       step;
  logic [1:0] cur_player;
  logic       busy;
  logic       done;

  modport master (
    output n_players, start, steps, pass_turn,
    input  p_da, step, cur_player, busy, done
  );

  modport slave (
    input  n_players, start, steps, pass_turn,
    output p_da, step, cur_player, busy, done
  );
endinterface

// File: rtl/move_sequencer.sv
// Turn/move sequencer: drives one step strobe per square to the active player's counter.
// Optional macro AUTO_PASS_EN: a zero-step move hands the turn on at DONE.
//
// state | meaning
// IDLE  | waiting for start or pass_turn; turn rotation happens here
// SETUP | enable of active player raised one cycle ahead of the first strobe
// PULSE | one step strobe, remaining count decremented
// GAP   | GAP_CYCLES spacing cycles with enable held
// DONE  | done pulse, enable dropped, back to IDLE
module move_sequencer #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_STEPS  = 15
) (
  input  logic clk,
  input  logic rst,
  move_sequencer_if.slave bus
);

  localparam int         GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [3:0] MAX_STEPS_L = 4'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      rem_q, rem_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      cur_player_q, cur_player_d;
`ifdef AUTO_PASS_EN
  logic            miss_q, miss_d;
`endif

  logic [2:0]      eff_cnt;
  logic [2:0]      player_inc;
  logic [1:0]      next_player;
  logic [3:0]      steps_clamped;

  // Out-of-range player counts collapse onto the nearest legal value.
  always_comb begin
    if (bus.n_players < 5'd2) begin
      eff_cnt = 3'd2;
    end else if (bus.n_players > 5'd4) begin
      eff_cnt = 3'd4;
    end else begin
      eff_cnt = bus.n_players[2:0];
    end
  end

  // A stale index beyond the current player count also lands on player 0.
  assign player_inc  = {1'b0, cur_player_q} + 3'd1;
  assign next_player = (player_inc >= eff_cnt) ? 2'd0 : player_inc[1:0];

  assign steps_clamped = (bus.steps > MAX_STEPS_L) ? MAX_STEPS_L : bus.steps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      gap_q        <= '0;
      cur_player_q <= '0;
`ifdef AUTO_PASS_EN
      miss_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      cur_player_q <= cur_player_d;
`ifdef AUTO_PASS_EN
      miss_q       <= miss_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    cur_player_d = cur_player_q;
`ifdef AUTO_PASS_EN
    miss_d       = miss_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = steps_clamped;
          state_d = S_SETUP;
`ifdef AUTO_PASS_EN
          miss_d  = (steps_clamped == 4'd0);
`endif
        end else if (bus.pass_turn) begin
          cur_player_d = next_player;
        end
      end

      S_SETUP: begin
        state_d = (rem_q == 4'd0) ? S_DONE : S_PULSE;
      end

      S_PULSE: begin
        rem_d   = rem_q - 4'd1;
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = (rem_q != 4'd0) ? S_PULSE : S_DONE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
`ifdef AUTO_PASS_EN
        if (miss_q) begin
          cur_player_d = next_player;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Enable spans SETUP..GAP so it brackets every strobe by at least one cycle.
  assign bus.p_da       = (state_q == S_SETUP || state_q == S_PULSE || state_q == S_GAP)
                          ? (4'b0001 << cur_player_q) : 4'b0000;
  assign bus.step       = (state_q == S_PULSE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.cur_player = cur_player_q;

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Turn and movement sequencer that drives the per-player position counters on the 24-square track. On a move request it selects the active player's advance enable and emits one step strobe per square moved. Strobes are spaced so each counter samples a stable enable and the move is visible on the display. It also owns turn rotation among 2–4 players. It sits between the card-match/game-control logic and the player position counters.

Parameters:
GAP_CYCLES, 4, clk cycles between consecutive step strobes (>=1)
MAX_STEPS, 15, largest legal steps value; larger requests clamp to this

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
n_players  input  5  number of players; legal 2..4
start  input  1  one-cycle move request, sampled in IDLE only
steps  input  4  squares to move, captured on accepted start
pass_turn  input  1  one-cycle request to hand the turn to the next player, IDLE only
p_da  output  4  one-hot advance enable, bit k = player k+1
step  output  1  step strobe to the position counters, one cycle high per square
cur_player  output  2  active player index 0..3
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse when a move completes

Behaviour:
- Reset values: p_da=0, step=0, cur_player=0, busy=0, done=0, state IDLE, internal counters 0. Reset mid-move aborts immediately. No further strobes are issued.
- Effective player count: n_players<2 is treated as 2; n_players>4 is treated as 4. Sampled continuously.
- States: IDLE, SETUP, PULSE, GAP, DONE.
- IDLE: busy=0. start=1 captures rem=min(steps,MAX_STEPS) and goes to SETUP. If start and pass_turn are both high, start wins and pass_turn is dropped.
- IDLE with pass_turn=1 and start=0: cur_player <= (cur_player+1) mod effective count. If cur_player >= effective count, it wraps to 0.
- SETUP (1 cycle): busy=1; p_da=one-hot(cur_player); step=0. If rem=0, go to DONE (no strobes). Otherwise go to PULSE.
- PULSE (1 cycle): step=1, p_da held, rem decrements, go to GAP.
- GAP (GAP_CYCLES cycles): step=0, p_da held. At the end: if rem>0, go to PULSE; else go to DONE.
- DONE (1 cycle): done=1, p_da=0, busy=1. Next state is IDLE.
- p_da is stable for >=1 cycle before the first strobe and after the last strobe, so a counter clocked on step always sees its enable high.
- Latency: first strobe in cycle 2 after start accepted (start cycle = 0). Strobe k (1-based) falls in cycle 2+(k-1)*(GAP_CYCLES+1). done falls GAP_CYCLES+1 cycles after the last strobe.
- start and pass_turn received while busy are ignored, not queued.
- cur_player does not change during a move. n_players changes mid-move take effect only for later rotations.
- Track wrap (23 -> 0) is owned by the counters; the sequencer never counts position.

Optional Feature:
AUTO_PASS_EN
- Defined: in the DONE state of a move whose captured rem was 0 (a miss), cur_player advances as if pass_turn were asserted. Moves with rem>0 keep the turn.
- Undefined: cur_player changes only through pass_turn and reset.

Test Plan:
- rst, n_players=4, steps=3, start pulse -> p_da=0001 from cycle 1. Strobes at cycles 2, 7, 12. done at cycle 17 with p_da=0. busy high in cycles 1–17.
- n_players=3, pass_turn x4 in IDLE -> cur_player 1, 2, 0, 1. n_players=9 -> same as 4: cur_player goes 0→1→2→3→0.
- steps=0 start -> no strobe, done 2 cycles after start. Also with AUTO_PASS_EN defined: cur_player 0→1 at done.
- steps=2 running, start and pass_turn pulsed mid-move -> ignored: exactly 2 strobes, cur_player unchanged.
- rst asserted mid-GAP after 1 of 5 strobes -> outputs 0 asynchronously. After release, no strobes until a new start.
- Simultaneous start and pass_turn in IDLE -> move executes for current player; cur_player unchanged.
